// File: rtl/line_memory_responder.sv
// Main-memory responder for whole-line fills (fixed-latency read bursts) and
// dirty-line write-backs (write bursts), one request outstanding at a time.
module line_memory_responder #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int LINE_WORDS = 16,
  parameter int READ_LAT   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rdata_valid,
  input  logic              rdata_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_last,
  output logic              wr_done
);

  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int LINE_W = ADDR_W - OFF_W;
  localparam int LAT_W  = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [OFF_W-1:0] LAST_IDX = OFF_W'(LINE_WORDS - 1);
  localparam logic [LAT_W-1:0] LAST_LAT = LAT_W'(READ_LAT - 1);

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_BURST, WR_BURST, WR_ACK} state_e;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  state_e            state_q, state_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [OFF_W-1:0]  idx_q, idx_d, idx_nxt;
  logic [LAT_W-1:0]  cnt_q, cnt_d;
  logic              req_ready_q, req_ready_d;
  logic              wdata_ready_q, wdata_ready_d;
  logic              rdata_valid_q, rdata_valid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rdata_last_q, rdata_last_d;
  logic              wr_done_q, wr_done_d;
  logic              mem_we;

  // Offset bits of the request address only select a word inside the line.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[OFF_W-1:0];

  assign idx_nxt = idx_q + OFF_W'(1);

  // NOTE: every *_d gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d       = state_q;
    line_d        = line_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    req_ready_d   = req_ready_q;
    wdata_ready_d = wdata_ready_q;
    rdata_valid_d = rdata_valid_q;
    rdata_d       = rdata_q;
    rdata_last_d  = rdata_last_q;
    wr_done_d     = wr_done_q;
    mem_we        = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          line_d      = req_addr[ADDR_W-1:OFF_W];
          idx_d       = '0;
          cnt_d       = '0;
          req_ready_d = 1'b0;
          if (req_write) begin
            state_d       = WR_BURST;
            wdata_ready_d = 1'b1;
          end else begin
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (cnt_q == LAST_LAT) begin
          state_d       = RD_BURST;
          rdata_valid_d = 1'b1;
          rdata_d       = mem[{line_q, idx_q}];
          rdata_last_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + LAT_W'(1);
        end
      end
      RD_BURST: begin
        if (rdata_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d       = IDLE;
            rdata_valid_d = 1'b0;
            rdata_last_d  = 1'b0;
            req_ready_d   = 1'b1;
          end else begin
            idx_d        = idx_nxt;
            rdata_d      = mem[{line_q, idx_nxt}];
            rdata_last_d = (idx_nxt == LAST_IDX);
          end
        end
      end
      WR_BURST: begin
        if (wdata_valid) begin
          mem_we = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d       = WR_ACK;
            wdata_ready_d = 1'b0;
            wr_done_d     = 1'b1;
          end else begin
            idx_d = idx_nxt;
          end
        end
      end
      WR_ACK: begin
        state_d     = IDLE;
        wr_done_d   = 1'b0;
        req_ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      line_q        <= '0;
      idx_q         <= '0;
      cnt_q         <= '0;
      req_ready_q   <= 1'b1;
      wdata_ready_q <= 1'b0;
      rdata_valid_q <= 1'b0;
      rdata_q       <= '0;
      rdata_last_q  <= 1'b0;
      wr_done_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      line_q        <= line_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      req_ready_q   <= req_ready_d;
      wdata_ready_q <= wdata_ready_d;
      rdata_valid_q <= rdata_valid_d;
      rdata_q       <= rdata_d;
      rdata_last_q  <= rdata_last_d;
      wr_done_q     <= wr_done_d;
    end
  end

  // NOTE: the array has no reset; reset only blocks a write on the edge it aborts.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[{line_q, idx_q}] <= wdata;
  end

  assign req_ready   = req_ready_q;
  assign wdata_ready = wdata_ready_q;
  assign rdata_valid = rdata_valid_q;
  assign rdata       = rdata_q;
  assign rdata_last  = rdata_last_q;
  assign wr_done     = wr_done_q;

endmodule

// File: tb/tb_line_memory_responder.sv
// Directed bench for line_memory_responder: reset, gapped write-back, fills with
// and without backpressure, top-line addressing and a reset-aborted write-back.
module tb_line_memory_responder;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic        wdata_valid;
  logic        wdata_ready;
  logic [15:0] wdata;
  logic        rdata_valid;
  logic        rdata_ready;
  logic [15:0] rdata;
  logic        rdata_last;
  logic        wr_done;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  logic [15:0] exp_words [16];

  line_memory_responder #(
    .ADDR_W(16), .DATA_W(16), .LINE_WORDS(16), .READ_LAT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_addr(req_addr),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata), .rdata_last(rdata_last),
    .wr_done(wr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic wr, input logic [15:0] addr);
    logic acc;
    logic ok;
    ok = 1'b0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    for (int c = 0; c < 20; c++) begin
      acc = req_ready;
      tick();
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    req_valid = 1'b0;
    check("req_accept", ok, 1);
  endtask

  task automatic send_words(input logic [15:0] base, input logic inc, input int n,
                            input logic gapped);
    int   i;
    int   cyc;
    logic acc;
    logic early;
    i = 0;
    cyc = 0;
    early = 1'b0;
    while (i < n && cyc < 200) begin
      wdata       = inc ? base + 16'(i) : base;
      wdata_valid = !gapped || (cyc % 2 == 0);
      acc         = wdata_valid && wdata_ready;
      tick();
      if (acc) i++;
      if (i < 16 && wr_done) early = 1'b1;
      cyc++;
    end
    wdata_valid = 1'b0;
    check("wr_word_count", i, n);
    check("wr_done_early", early, 0);
  endtask

  task automatic write_line(input logic [15:0] addr, input logic [15:0] base, input logic inc,
                            input logic gapped);
    start_req(1'b1, addr);
    send_words(base, inc, 16, gapped);
    check("wr_done_pulse", wr_done, 1);
    check("wr_ack_wdata_ready", wdata_ready, 0);
    check("wr_ack_req_ready", req_ready, 0);
    tick();
    check("wr_done_drop", wr_done, 0);
    check("wr_idle_req_ready", req_ready, 1);
  endtask

  task automatic read_line(input logic [15:0] addr, input logic bp);
    int   k;
    int   n;
    int   cyc;
    int   bubbles;
    logic rr;
    logic stalled;
    logic [15:0] prev_data;
    logic prev_last;
    start_req(1'b0, addr);
    k = 0;
    while (!rdata_valid && k < 20) begin
      tick();
      k++;
    end
    check("rd_latency", k, 4);
    n = 0;
    cyc = 0;
    bubbles = 0;
    stalled = 1'b0;
    prev_data = '0;
    prev_last = 1'b0;
    while (n < 16 && cyc < 400) begin
      if (!rdata_valid) bubbles++;
      if (stalled) begin
        check("rd_stall_data", rdata, prev_data);
        check("rd_stall_last", rdata_last, prev_last);
      end
      rr = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      rdata_ready = rr;
      if (rdata_valid && rr) begin
        check($sformatf("rd_word%0d", n), rdata, exp_words[n]);
        check($sformatf("rd_last%0d", n), rdata_last, (n == 15) ? 1 : 0);
        n++;
        stalled = 1'b0;
      end else begin
        stalled = rdata_valid;
      end
      prev_data = rdata;
      prev_last = rdata_last;
      tick();
      cyc++;
    end
    rdata_ready = 1'b0;
    check("rd_transfers", n, 16);
    check("rd_bubbles", bubbles, 0);
    if (!bp) check("rd_cycles", cyc, 16);
    check("rd_valid_drop", rdata_valid, 0);
    check("rd_last_drop", rdata_last, 0);
    check("rd_idle_req_ready", req_ready, 1);
  endtask

  initial begin
    logic seen_valid;
    logic lost_ready;
    rst = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr = 16'h1230;
    wdata_valid = 1'b0;
    wdata = '0;
    rdata_ready = 1'b0;

    // Reset held two cycles while a fill request is presented.
    tick();
    tick();
    check("rst_req_ready", req_ready, 1);
    check("rst_rdata_valid", rdata_valid, 0);
    check("rst_wdata_ready", wdata_ready, 0);
    check("rst_wr_done", wr_done, 0);
    check("rst_rdata", rdata, 0);
    check("rst_rdata_last", rdata_last, 0);
    rst = 1'b0;
    req_valid = 1'b0;
    seen_valid = 1'b0;
    lost_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (rdata_valid) seen_valid = 1'b1;
      if (!req_ready) lost_ready = 1'b1;
    end
    check("rst_no_burst_valid", seen_valid, 0);
    check("rst_no_burst_ready", lost_ready, 0);

    // Gapped write-back, then stray write words while idle.
    write_line(16'h1237, 16'hA000, 1'b1, 1'b1);
    wdata_valid = 1'b1;
    wdata = 16'hDEAD;
    tick();
    tick();
    tick();
    wdata_valid = 1'b0;

    for (int i = 0; i < 16; i++) exp_words[i] = 16'hA000 + 16'(i);
    read_line(16'h1235, 1'b0);
    read_line(16'h123C, 1'b1);

    // Top line must not wrap into line 0.
    write_line(16'h0000, 16'h7700, 1'b1, 1'b0);
    write_line(16'hFFF0, 16'h5A00, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) exp_words[i] = 16'h5A00 + 16'(i);
    read_line(16'hFFFF, 1'b0);
    for (int i = 0; i < 16; i++) exp_words[i] = 16'h7700 + 16'(i);
    read_line(16'h0000, 1'b0);

    // Write-back aborted by reset after five words; the reset edge carries a write word.
    write_line(16'h2000, 16'h1111, 1'b0, 1'b0);
    start_req(1'b1, 16'h2000);
    send_words(16'hB000, 1'b1, 5, 1'b0);
    rst = 1'b1;
    wdata_valid = 1'b1;
    wdata = 16'hEEEE;
    tick();
    rst = 1'b0;
    wdata_valid = 1'b0;
    check("abort_req_ready", req_ready, 1);
    check("abort_wdata_ready", wdata_ready, 0);
    check("abort_wr_done", wr_done, 0);
    seen_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (wr_done) seen_valid = 1'b1;
    end
    check("abort_no_wr_done", seen_valid, 0);
    for (int i = 0; i < 16; i++) exp_words[i] = (i < 5) ? 16'hB000 + 16'(i) : 16'h1111;
    read_line(16'h2000, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/line_memory_responder.md
Name: line_memory_responder

Overview:
- Main-memory responder at the far end of the write-back cache's line-transfer interface.
- Serves two kinds of whole-line request, one outstanding at a time:
  - line fills (read bursts) with a fixed access latency;
  - dirty-line write-backs (write bursts).
- Owns the backing word array of 2^ADDR_W words of DATA_W bits.

Parameters:
- ADDR_W, 16, word-address width; the array holds 2^ADDR_W words.
- DATA_W, 16, word width.
- LINE_WORDS, 16, words per cache line; power of two, at least 2.
- READ_LAT, 4, cycles from read-request acceptance to the first valid read word; at least 1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = write-back burst, 0 = fill burst.
- req_addr  in  ADDR_W  word address; the low log2(LINE_WORDS) bits are ignored.
- wdata_valid  in  1  write word present.
- wdata_ready  out  1  responder accepts a write word.
- wdata  in  DATA_W  write word.
- rdata_valid  out  1  read word present.
- rdata_ready  in  1  requester accepts the read word.
- rdata  out  DATA_W  read word.
- rdata_last  out  1  marks the final word of a fill.
- wr_done  out  1  one-cycle pulse when a write-back completes.

Behaviour:
- Reset values:
  - outputs: req_ready=1, wdata_ready=0, rdata_valid=0, rdata=0, rdata_last=0, wr_done=0.
  - control: state=IDLE, counters=0.
  - The array is not cleared by reset.
- Request handshake:
  - A request is accepted on an edge where req_valid=1 and req_ready=1.
  - req_ready=1 only in IDLE.
  - On acceptance, latch base = req_addr with the low bits cleared, and latch req_write.
- States and transitions:
  - IDLE: on accept, go to RD_WAIT if req_write=0, otherwise WR_BURST.
  - RD_WAIT: the latency counter runs for READ_LAT cycles. rdata_valid first reads 1 in the cycle after edge E0+READ_LAT, where E0 is the accept edge. Rdata then holds mem[base]. Go to RD_BURST.
  - RD_BURST:
    - Present mem[base+i] for i=0..LINE_WORDS-1, in ascending order.
    - A word transfers on an edge with rdata_valid=1 and rdata_ready=1.
    - While rdata_ready=0, rdata, rdata_valid and rdata_last hold stable.
    - With rdata_ready held at 1, one word transfers per cycle with no bubbles.
    - rdata_last=1 only with word LINE_WORDS-1.
    - After the last transfer, rdata_valid and rdata_last drop to 0 and the state returns to IDLE.
  - WR_BURST:
    - wdata_ready=1.
    - Each edge with wdata_valid=1 writes mem[base+i]=wdata, then i increments.
    - On the edge that accepts word LINE_WORDS-1, go to WR_ACK and deassert wdata_ready.
  - WR_ACK: wr_done=1 for exactly one cycle, then IDLE. req_ready is 1 again in the following cycle.
- Addressing:
  - base+i never carries out of the line.
  - The top line (all ones, low bits 0) ends exactly at 2^ADDR_W-1; there is no wrap to 0.
- Ordering:
  - A fill that follows a write-back of the same line returns the new data.
  - A back-to-back request presented while in WR_ACK or after rdata_last is accepted no earlier than the first IDLE cycle.
- wdata_valid outside WR_BURST is ignored, and the array is unchanged.
- rdata_ready outside RD_BURST is ignored.
- Reset mid-operation: the burst is aborted and all outputs return to their reset values on that edge.
  - Words already written in an aborted write-back remain; the rest of the line is unchanged.
  - No wr_done is produced for an aborted write-back.
  - An aborted fill produces no further rdata_valid.
- Simultaneous rst and req_valid: reset wins and the request is not accepted.

Test Plan:
- Reset: assert rst for 2 cycles with req_valid=1 -> req_ready=1; rdata_valid, wdata_ready, wr_done all 0; no burst started.
- Write-back: req_write=1, req_addr=0x1237, wdata=0xA000+i with wdata_valid gapped every other cycle -> mem[0x1230..0x123F]=0xA000..0xA00F, wr_done a single pulse after the 16th accept, req_ready=1 the next cycle.
- Fill, no backpressure:
  - Stimulus: req_write=0, req_addr=0x1235 after the write-back above, rdata_ready=1.
  - Response: first rdata_valid READ_LAT=4 cycles after the accept edge; 0xA000..0xA00F on 16 consecutive cycles; rdata_last only with 0xA00F.
- Fill with backpressure: rdata_ready pseudo-random 50% -> no word dropped or duplicated, rdata stable while stalled, exactly 16 transfers.
- Top line: write 0xFFF0 line with 0x5A00+i, then fill 0xFFFF -> returns 0x5A00..0x5A0F; mem[0x0000] unchanged.
- Reset mid write-back:
  - Stimulus: rst after 5 words written to line 0x2000 preloaded with 0x1111.
  - Response: idle, no wr_done; 0x2000..0x2004 hold new data; 0x2005..0x200F read back 0x1111.
